shake_squeezer: RTL and testbench

SHAKE_SQUEEZER -- requirements
Module: shake_squeezer

---
 rtl/shake_pkg.sv | 18 +
 rtl/sqz_lane_sel.sv | 22 ++
 rtl/shake_squeezer.sv | 154 +++++++++++++++
 tb/tb_shake_squeezer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// rtl/shake_pkg.sv - shared constants and FSM state type for the SHAKE squeezer
package shake_pkg;

  localparam int KECCAK_B      = 1600;
  localparam int LANE_W        = 64;
  localparam int SHAKE128_RATE = 1344;
  localparam int SHAKE256_RATE = 1088;
  // Wide enough to hold the lane count itself (21 for SHAKE128), not just the last index.
  localparam int LANE_IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT      = 2'd1,
    PERM_REQ  = 2'd2,
    PERM_WAIT = 2'd3
  } sqz_state_t;

endpackage

// File: rtl/sqz_lane_sel.sv
// rtl/sqz_lane_sel.sv - combinational lane-index to 64-bit word mux over the rate portion
module sqz_lane_sel
  import shake_pkg::*;
#(
  parameter int RATE = SHAKE256_RATE
) (
  input  logic [RATE-1:0]       rate_bits,
  input  logic [LANE_IDX_W-1:0] idx,
  output logic [LANE_W-1:0]     word
);

  // Indices at or past the lane count select zero; the caller never emits them.
  always_comb begin
    word = '0;
    for (int k = 0; k < RATE / LANE_W; k++) begin
      if (idx == LANE_IDX_W'(k)) begin
        word = rate_bits[k*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/shake_squeezer.sv
// rtl/shake_squeezer.sv - SHAKE output squeezer with external Keccak permutation
// Optional abort input when SHAKE_SQZ_ABORT_EN is defined.
module shake_squeezer
  import shake_pkg::*;
#(
  parameter int RATE  = SHAKE256_RATE,
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KECCAK_B-1:0] state_in,
  input  logic [LEN_W-1:0]    out_len,
  input  logic                load,
  output logic                load_ready,
`ifdef SHAKE_SQZ_ABORT_EN
  input  logic                abort,
`endif
  output logic [LANE_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                perm_start,
  output logic [KECCAK_B-1:0] perm_state,
  input  logic [KECCAK_B-1:0] perm_result,
  input  logic                perm_done
);

  localparam int LANES = RATE / LANE_W;
  localparam logic [LANE_IDX_W-1:0] LANE_END = LANE_IDX_W'(LANES);

  sqz_state_t            fsm_q, fsm_d;
  logic [KECCAK_B-1:0]   state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic [LANE_W-1:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_last_q, dout_last_d;
  logic                  perm_start_q, perm_start_d;

  logic [LEN_W-1:0]      rem_nxt;
  logic [LANE_IDX_W-1:0] lane_nxt;
  logic [LANE_W-1:0]     next_word;

  assign rem_nxt  = rem_q - LEN_W'(1);
  assign lane_nxt = lane_q + LANE_IDX_W'(1);

  sqz_lane_sel #(.RATE(RATE)) u_lane_sel (
    .rate_bits (state_q[RATE-1:0]),
    .idx       (lane_nxt),
    .word      (next_word)
  );

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    rem_d        = rem_q;
    lane_d       = lane_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    perm_start_d = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (load && (out_len != '0)) begin
          fsm_d        = EMIT;
          state_d      = state_in;
          rem_d        = out_len;
          lane_d       = '0;
          dout_d       = state_in[LANE_W-1:0];
          dout_valid_d = 1'b1;
          dout_last_d  = (out_len == LEN_W'(1));
        end
      end
      // dout_valid is always high in EMIT, so dout_ready alone marks a handshake.
      EMIT: begin
        if (dout_ready) begin
          rem_d  = rem_nxt;
          lane_d = lane_nxt;
          if (rem_nxt == '0) begin
            fsm_d        = IDLE;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
          end else if (lane_nxt == LANE_END) begin
            fsm_d        = PERM_REQ;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            perm_start_d = 1'b1;
          end else begin
            dout_d      = next_word;
            dout_last_d = (rem_nxt == LEN_W'(1));
          end
        end
      end
      PERM_REQ: begin
        fsm_d = PERM_WAIT;
      end
      PERM_WAIT: begin
        if (perm_done) begin
          fsm_d        = EMIT;
          state_d      = perm_result;
          lane_d       = '0;
          dout_d       = perm_result[LANE_W-1:0];
          dout_valid_d = 1'b1;
          dout_last_d  = (rem_q == LEN_W'(1));
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

`ifdef SHAKE_SQZ_ABORT_EN
    if (abort) begin
      fsm_d        = IDLE;
      rem_d        = '0;
      lane_d       = '0;
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      perm_start_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q        <= IDLE;
      state_q      <= '0;
      rem_q        <= '0;
      lane_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      rem_q        <= rem_d;
      lane_q       <= lane_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign load_ready = (fsm_q == IDLE);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign perm_start = perm_start_q;
  assign perm_state = state_q;

endmodule

// File: tb/tb_shake_squeezer.sv
// tb/tb_shake_squeezer.sv - scoreboard bench for shake_squeezer (RATE=1088)
module tb_shake_squeezer;

  localparam int RATE  = 1088;
  localparam int LEN_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [1599:0]     state_in;
  logic [LEN_W-1:0]  out_len;
  logic              load;
  logic              load_ready;
  logic [63:0]       dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              perm_start;
  logic [1599:0]     perm_state;
  logic [1599:0]     perm_result;
  logic              perm_done;
  logic              abort_mon;
`ifdef SHAKE_SQZ_ABORT_EN
  logic              abort;
  assign abort_mon = abort;
`else
  assign abort_mon = 1'b0;
`endif

  shake_squeezer #(.RATE(RATE), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .state_in    (state_in),
    .out_len     (out_len),
    .load        (load),
    .load_ready  (load_ready),
`ifdef SHAKE_SQZ_ABORT_EN
    .abort       (abort),
`endif
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .perm_start  (perm_start),
    .perm_state  (perm_state),
    .perm_result (perm_result),
    .perm_done   (perm_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int perm_pulses = 0;
  logic [64:0] exp_q[$];

  function automatic logic [1599:0] make_state(input int base);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[i*64 +: 64] = 64'(base + i);
    return s;
  endfunction

  // Scoreboard: every handshake seen between edges pops one expected {last, word}.
  always @(negedge clk) begin
    logic [64:0] e;
    if (perm_start) perm_pulses++;
    if (reset && dout_valid && dout_ready && !abort_mon) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got last=%b data=%h, expected no word", dout_last, dout);
      end else begin
        e = exp_q.pop_front();
        if ({dout_last, dout} !== e) begin
          n_fail++;
          $display("FAIL dout_word: got last=%b data=%h, expected last=%b data=%h",
                   dout_last, dout, e[64], e[63:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int base, input int from, input int to, input bit last_at_end);
    logic l;
    for (int k = from; k <= to; k++) begin
      l = last_at_end && (k == to);
      exp_q.push_back({l, 64'(base + k)});
    end
  endtask

  task automatic do_load(input int len, input int base);
    state_in = make_state(base);
    out_len  = LEN_W'(len);
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic drain(input string name, output int cycles);
    cycles = 0;
    while ((exp_q.size() != 0 || dout_valid) && cycles < 300) begin
      step();
      cycles++;
    end
    n_checks++;
    if (cycles >= 300) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d words left, expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_perm_start(input string name);
    int c = 0;
    while (!perm_start && c < 100) begin
      step();
      c++;
    end
    n_checks++;
    if (!perm_start) begin
      n_fail++;
      $display("FAIL %s_perm_start: got 0, expected 1 within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; out_len = '0; state_in = '0;
    dout_ready = 1'b0; perm_result = '0; perm_done = 1'b0;
`ifdef SHAKE_SQZ_ABORT_EN
    abort = 1'b0;
`endif
    step(); step();
    n_checks++;
    if ({dout_valid, dout_last, perm_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags: got valid/last/start=%b, expected 000", {dout_valid, dout_last, perm_start});
    end
    n_checks++;
    if (dout !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_dout: got %h, expected 0", dout);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_load_ready: got %b, expected 1", load_ready);
    end
  endtask

  task automatic test_short();
    int cyc;
    perm_pulses = 0;
    dout_ready = 1'b1;
    push_range(0, 0, 3, 1'b1);
    do_load(4, 0);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== 64'd0) begin
      n_fail++;
      $display("FAIL short_latency: got valid=%b data=%h, expected valid=1 data=0", dout_valid, dout);
    end
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL short_load_ready_busy: got %b, expected 0", load_ready);
    end
    drain("short", cyc);
    n_checks++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL short_cycles: got %0d, expected 4", cyc);
    end
    n_checks++;
    if (perm_pulses != 0 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL short_end: got perm_pulses=%0d load_ready=%b, expected 0 and 1", perm_pulses, load_ready);
    end
  endtask

  task automatic test_perm();
    int cyc;
    perm_pulses = 0;
    dout_ready = 1'b1;
    push_range(0, 0, 16, 1'b1);
    do_load(17, 0);
    drain("len17", cyc);
    n_checks++;
    if (cyc != 17 || perm_pulses != 0) begin
      n_fail++;
      $display("FAIL len17: got cycles=%0d perm_pulses=%0d, expected 17 and 0", cyc, perm_pulses);
    end
    push_range(40, 0, 0, 1'b1);
    do_load(1, 40);
    drain("len1", cyc);
    n_checks++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL len1_cycles: got %0d, expected 1", cyc);
    end
    perm_pulses = 0;
    push_range(0, 0, 16, 1'b0);
    push_range(100, 0, 0, 1'b1);
    do_load(18, 0);
    wait_perm_start("len18");
    n_checks++;
    if (perm_state !== make_state(0)) begin
      n_fail++;
      $display("FAIL perm_state: got lane16=%h, expected lane16=%h", perm_state[16*64 +: 64], 64'd16);
    end
    step();
    n_checks++;
    if (perm_start !== 1'b0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL perm_wait_flags: got start=%b valid=%b, expected 0 0", perm_start, dout_valid);
    end
    perm_result = make_state(100);
    step(); step();
    perm_done = 1'b1;
    step();
    perm_done = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== 64'd100 || dout_last !== 1'b1) begin
      n_fail++;
      $display("FAIL perm_resume: got valid=%b data=%h last=%b, expected 1 64 1",
               dout_valid, dout, dout_last);
    end
    drain("len18", cyc);
    n_checks++;
    if (perm_pulses != 1) begin
      n_fail++;
      $display("FAIL len18_pulses: got %0d, expected 1", perm_pulses);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int c = 0;
    dout_ready = 1'b1;
    push_range(0, 0, 5, 1'b1);
    do_load(6, 0);
    while (!(dout_valid && dout == 64'd2) && c < 20) begin
      step();
      c++;
    end
    dout_ready  = 1'b0;
    load        = 1'b1;
    out_len     = LEN_W'(3);
    state_in    = make_state(500);
    perm_result = make_state(900);
    perm_done   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0;
      perm_done = 1'b0;
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== 64'd2 || dout_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got valid=%b data=%h last=%b, expected 1 2 0",
                 i, dout_valid, dout, dout_last);
      end
    end
    dout_ready = 1'b1;
    drain("backpressure", cyc);
  endtask

  task automatic test_len_zero();
    do_load(0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dout_valid !== 1'b0 || load_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL len0_%0d: got valid=%b load_ready=%b, expected 0 1", i, dout_valid, load_ready);
      end
      step();
    end
  endtask

  task automatic test_reset_perm();
    dout_ready = 1'b1;
    push_range(0, 0, 16, 1'b0);
    do_load(18, 0);
    wait_perm_start("rstperm");
    step();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || perm_start !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstperm_async: got valid=%b start=%b queued=%0d, expected 0 0 0",
               dout_valid, perm_start, exp_q.size());
    end
    step();
    reset = 1'b1;
    perm_result = make_state(100);
    perm_done = 1'b1;
    step();
    perm_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({dout_valid, dout_last, perm_start, load_ready} !== 4'b0001 || dout !== 64'd0) begin
        n_fail++;
        $display("FAIL rstperm_after_%0d: got valid/last/start/ready=%b data=%h, expected 0001 0",
                 i, {dout_valid, dout_last, perm_start, load_ready}, dout);
      end
      step();
    end
  endtask

`ifdef SHAKE_SQZ_ABORT_EN
  task automatic test_abort();
    int cyc;
    dout_ready = 1'b1;
    push_range(0, 0, 0, 1'b0);
    do_load(5, 0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b0 || load_ready !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_idle: got valid=%b ready=%b queued=%0d, expected 0 1 0",
               dout_valid, load_ready, exp_q.size());
    end
    push_range(10, 0, 1, 1'b1);
    do_load(2, 10);
    drain("abort_reload", cyc);
    n_checks++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL abort_reload_cycles: got %0d, expected 2", cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_short();
    test_perm();
    test_backpressure();
    test_len_zero();
    test_reset_perm();
`ifdef SHAKE_SQZ_ABORT_EN
    test_abort();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
